// File: rtl/task_distribute_rr.sv
// task_distribute_rr: hands head tasks from the per-level TaskFIFOs to idle RPUs.
// Pop priority starts at a rotating anchor. A level whose head has been blocked
// for STARVE_LIMIT cycles takes over the anchor.
// Optional stall statistics are enabled by defining TASK_DIST_STATS_EN.
module task_distribute_rr #(
   parameter int PTW           = 16,
   parameter int LEVEL         = 4,
   parameter int TREE_NUM      = 4,
   parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
   parameter int STARVE_LIMIT  = 8,
   parameter int CNT_W         = $clog2(STARVE_LIMIT+1)
) (
   input  logic                                   i_clk,
   input  logic                                   i_arst,
   output logic [LEVEL-1:0]                       o_pop_TaskFIFO,
   input  logic [LEVEL-1:0][PTW+TREE_NUM_BITS:0]  i_TaskFIFO_data,
   input  logic [LEVEL-1:0]                       i_TaskFIFO_empty,
   input  logic [LEVEL-1:0][1:0]                  i_rpu_state_nxt,
   output logic [LEVEL-1:0]                       o_rpu_push,
   output logic [LEVEL-1:0]                       o_rpu_pop,
   output logic [LEVEL-1:0][TREE_NUM_BITS-1:0]    o_rpu_treeId,
   output logic [LEVEL-1:0][PTW-1:0]              o_rpu_push_data,
   output logic [$clog2(LEVEL)-1:0]               o_anchor,
   output logic [LEVEL-1:0][15:0]                 o_stall_cnt
);
   localparam int          TW  = PTW + TREE_NUM_BITS + 1;
   localparam int          AW  = $clog2(LEVEL);
   localparam int unsigned LVL = LEVEL;

   typedef enum logic [1:0] {
      RPU_IDLE = 2'b00,
      RPU_PUSH = 2'b01,
      RPU_WB   = 2'b10,
      RPU_POP  = 2'b11
   } rpu_state_e;

   logic [LEVEL-1:0]                    pop_last_q, pop_last_d;
   logic [LEVEL-1:0]                    empty_last_q, empty_last_d;
   logic [LEVEL-1:0]                    head_v_q, head_v_d;
   logic [LEVEL-1:0][TW-1:0]            head_task_q, head_task_d;
   logic [LEVEL-1:0]                    head_v;
   logic [LEVEL-1:0][TW-1:0]            head_task;
   logic [LEVEL-1:0]                    idle, is_push;
   logic [LEVEL-1:0]                    push_nxt, pop_nxt, issued;
   logic [LEVEL-1:0][CNT_W-1:0]         wait_q, wait_d;
   logic [AW-1:0]                       anchor_q, anchor_d;
   logic [LEVEL-1:0]                    push_q, pop_q;
   logic [LEVEL-1:0][TREE_NUM_BITS-1:0] tree_q, tree_d;
   logic [LEVEL-1:0][PTW-1:0]           data_q, data_d;

   // Current head per level: freshly popped FIFO word or the held task.
   always_comb begin
      for (int unsigned i = 0; i < LVL; i++) begin
         idle[i]      = (i_rpu_state_nxt[i] == RPU_IDLE);
         head_v[i]    = pop_last_q[i] ? ~empty_last_q[i] : head_v_q[i];
         head_task[i] = pop_last_q[i] ? i_TaskFIFO_data[i] : head_task_q[i];
         is_push[i]   = head_task[i][TW-1];
      end
   end

   // Issue decision: the anchor pop is resolved first, then pushes, then the pop chain.
   // Each later level in the chain depends on its predecessor, so the chain
   // walks rr+1 .. rr+LEVEL-1 in order.
   always_comb begin
      int unsigned rr, rp, idx, p;
      push_nxt = '0;
      pop_nxt  = '0;
      rr       = 32'(anchor_q);
      rp       = (rr + LVL - 1) % LVL;
      idx      = 0;
      p        = 0;
      pop_nxt[rr] = idle[rr] & idle[rp] & head_v[rr] & ~is_push[rr];
      for (int unsigned i = 0; i < LVL; i++) begin
         push_nxt[i] = idle[i] & head_v[i] & is_push[i] & ~((i == rp) & pop_nxt[rr]);
      end
      for (int unsigned k = 1; k < LVL; k++) begin
         idx = (rr + k) % LVL;
         p   = (idx + LVL - 1) % LVL;
         pop_nxt[idx] = idle[idx] & idle[p] & ~(push_nxt[p] | pop_nxt[p]) &
                        head_v[idx] & ~is_push[idx] & ~((idx == rp) & pop_nxt[rr]);
      end
      issued = push_nxt | pop_nxt;
   end

   // Next-state: head retirement, FIFO strobe, starvation counters, anchor takeover.
   always_comb begin
      int unsigned lv;
      lv           = 0;
      anchor_d     = anchor_q;
      pop_last_d   = '0;
      empty_last_d = i_TaskFIFO_empty;
      for (int unsigned i = 0; i < LVL; i++) begin
         head_v_d[i]       = head_v[i] & ~issued[i];
         head_task_d[i]    = issued[i] ? '0 : head_task[i];
         o_pop_TaskFIFO[i] = ~head_v_d[i] & ~i_TaskFIFO_empty[i];
         pop_last_d[i]     = o_pop_TaskFIFO[i];
         tree_d[i]         = head_task[i][PTW +: TREE_NUM_BITS];
         data_d[i]         = head_task[i][PTW-1:0];
         if (issued[i] || !head_v[i])
            wait_d[i] = '0;
         else if (idle[i] && (wait_q[i] != CNT_W'(STARVE_LIMIT)))
            wait_d[i] = wait_q[i] + CNT_W'(1);
         else
            wait_d[i] = wait_q[i];
      end
      // Scanning downward leaves the lowest saturated index as the winner.
      for (int unsigned k = 0; k < LVL; k++) begin
         lv = LVL - 1 - k;
         if (wait_d[lv] == CNT_W'(STARVE_LIMIT)) anchor_d = AW'(lv);
      end
   end

   // State and registered outputs.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         pop_last_q   <= '0;
         empty_last_q <= '0;
         head_v_q     <= '0;
         head_task_q  <= '0;
         wait_q       <= '0;
         anchor_q     <= AW'(1);
         push_q       <= '0;
         pop_q        <= '0;
         tree_q       <= '0;
         data_q       <= '0;
      end else begin
         pop_last_q   <= pop_last_d;
         empty_last_q <= empty_last_d;
         head_v_q     <= head_v_d;
         head_task_q  <= head_task_d;
         wait_q       <= wait_d;
         anchor_q     <= anchor_d;
         push_q       <= push_nxt;
         pop_q        <= pop_nxt;
         tree_q       <= tree_d;
         data_q       <= data_d;
      end
   end

   assign o_rpu_push      = push_q;
   assign o_rpu_pop       = pop_q;
   assign o_rpu_treeId    = tree_q;
   assign o_rpu_push_data = data_q;
   assign o_anchor        = anchor_q;

`ifdef TASK_DIST_STATS_EN
   logic [LEVEL-1:0][15:0] stall_q, stall_d;

   // Saturating count of cycles a valid head waits without issuing.
   always_comb begin
      for (int unsigned i = 0; i < LVL; i++) begin
         stall_d[i] = stall_q[i];
         if (head_v[i] && !issued[i] && (stall_q[i] != '1))
            stall_d[i] = stall_q[i] + 16'd1;
      end
   end

   // Stall counter registers.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) stall_q <= '0;
      else        stall_q <= stall_d;
   end

   assign o_stall_cnt = stall_q;
`else
   assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_task_distribute_rr.sv
// Directed bench for task_distribute_rr with a behavioural TaskFIFO per level.
module tb_task_distribute_rr;
   localparam int PTW   = 16;
   localparam int LEVEL = 4;
   localparam int TB    = 2;
   localparam int TW    = PTW + TB + 1;
`ifdef TASK_DIST_STATS_EN
   localparam logic [15:0] EXP_STALL5 = 16'd5;
`else
   localparam logic [15:0] EXP_STALL5 = 16'd0;
`endif

   logic                       clk = 1'b0;
   logic                       arst;
   logic [LEVEL-1:0]           o_pop, empty, push, pop;
   logic [LEVEL-1:0][TW-1:0]   fdata;
   logic [LEVEL-1:0][1:0]      st;
   logic [LEVEL-1:0][TB-1:0]   tree;
   logic [LEVEL-1:0][PTW-1:0]  data;
   logic [1:0]                 anchor;
   logic [LEVEL-1:0][15:0]     stall;
   int                         checks = 0;
   int                         errors = 0;

   logic [TW-1:0] mem [LEVEL][32];
   int unsigned   wr  [LEVEL];
   int unsigned   rd  [LEVEL];

   always #5 clk = ~clk;

   task_distribute_rr #(.PTW(PTW), .LEVEL(LEVEL), .TREE_NUM(4), .STARVE_LIMIT(8)) dut (
      .i_clk(clk), .i_arst(arst), .o_pop_TaskFIFO(o_pop), .i_TaskFIFO_data(fdata),
      .i_TaskFIFO_empty(empty), .i_rpu_state_nxt(st), .o_rpu_push(push), .o_rpu_pop(pop),
      .o_rpu_treeId(tree), .o_rpu_push_data(data), .o_anchor(anchor), .o_stall_cnt(stall)
   );

   always_comb begin
      for (int i = 0; i < LEVEL; i++) empty[i] = (rd[i] == wr[i]);
   end

   // FIFO model: read data appears the cycle after the strobe; reset drops contents.
   always @(posedge clk) begin
      for (int i = 0; i < LEVEL; i++) begin
         if (arst) begin
            rd[i]    <= wr[i];
            fdata[i] <= '0;
         end else if (o_pop[i] && (rd[i] != wr[i])) begin
            fdata[i] <= mem[i][rd[i][4:0]];
            rd[i]    <= rd[i] + 1;
         end
      end
   end

   task automatic load(input int lvl, input logic typ, input logic [1:0] tr, input logic [15:0] d);
      mem[lvl][wr[lvl][4:0]] = {typ, tr, d};
      wr[lvl] = wr[lvl] + 1;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      st   = '0;
      arst = 1'b1;
      @(negedge clk);
      arst = 1'b0;
   endtask

   task automatic test_reset();
      st   = '0;
      arst = 1'b1;
      step();
      checks++;
      if (push !== 4'b0 || pop !== 4'b0) begin
         errors++; $display("FAIL reset_cmd got push=%b pop=%b exp 0000/0000", push, pop);
      end
      checks++;
      if (tree !== '0 || data !== '0) begin
         errors++; $display("FAIL reset_fields got tree=%h data=%h exp 0", tree, data);
      end
      checks++;
      if (anchor !== 2'd1) begin
         errors++; $display("FAIL reset_anchor got %0d exp 1", anchor);
      end
      checks++;
      if (o_pop !== 4'b0 || stall !== '0) begin
         errors++; $display("FAIL reset_misc got fifo_pop=%b stall=%h exp 0", o_pop, stall);
      end
      arst = 1'b0;
   endtask

   task automatic test_push_basic();
      do_reset();
      load(0, 1'b1, 2'd2, 16'h00AB);
      #1;
      checks++;
      if (o_pop !== 4'b0001) begin
         errors++; $display("FAIL push_fifo_pop got %b exp 0001", o_pop);
      end
      step();
      step();
      checks++;
      if (push !== 4'b0001 || pop !== 4'b0000) begin
         errors++; $display("FAIL push_issue got push=%b pop=%b exp 0001/0000", push, pop);
      end
      checks++;
      if (tree[0] !== 2'd2 || data[0] !== 16'h00AB) begin
         errors++; $display("FAIL push_fields got tree=%0d data=%h exp 2/00ab", tree[0], data[0]);
      end
      step();
      checks++;
      if (push !== 4'b0000) begin
         errors++; $display("FAIL push_once got %b exp 0000", push);
      end
   endtask

   task automatic test_push_pop_hazard();
      do_reset();
      load(0, 1'b1, 2'd1, 16'h1111);
      load(1, 1'b0, 2'd3, 16'h0000);
      step();
      step();
      checks++;
      if (pop !== 4'b0010 || push !== 4'b0000) begin
         errors++; $display("FAIL hazard_first got pop=%b push=%b exp 0010/0000", pop, push);
      end
      step();
      checks++;
      if (push !== 4'b0001 || pop !== 4'b0000) begin
         errors++; $display("FAIL hazard_second got push=%b pop=%b exp 0001/0000", push, pop);
      end
      checks++;
      if (tree[0] !== 2'd1 || data[0] !== 16'h1111) begin
         errors++; $display("FAIL hazard_fields got tree=%0d data=%h exp 1/1111", tree[0], data[0]);
      end
   endtask

   task automatic test_all_pop();
      do_reset();
      for (int l = 0; l < LEVEL; l++) load(l, 1'b0, l[1:0], 16'h0);
      step();
      step();
      checks++;
      if (pop !== 4'b1010 || push !== 4'b0000) begin
         errors++; $display("FAIL allpop_first got pop=%b push=%b exp 1010/0000", pop, push);
      end
      step();
      checks++;
      if (pop !== 4'b0101) begin
         errors++; $display("FAIL allpop_second got pop=%b exp 0101", pop);
      end
   endtask

   task automatic test_starve_hold();
      do_reset();
      st[0] = 2'b01;
      load(1, 1'b0, 2'd0, 16'h0);
      for (int n = 1; n <= 12; n++) begin
         step();
         checks++;
         if (pop !== 4'b0000 || anchor !== 2'd1) begin
            errors++; $display("FAIL hold_blocked c%0d got pop=%b anchor=%0d exp 0000/1", n, pop, anchor);
         end
      end
      checks++;
      if (dut.wait_q[1] !== 4'd8) begin
         errors++; $display("FAIL hold_wait_sat got %0d exp 8", dut.wait_q[1]);
      end
      st[0] = 2'b00;
      step();
      checks++;
      if (pop !== 4'b0010 || dut.wait_q[1] !== 4'd0) begin
         errors++; $display("FAIL hold_release got pop=%b wait=%0d exp 0010/0", pop, dut.wait_q[1]);
      end
   endtask

   task automatic test_starve_seize();
      logic [3:0] eu, ep;
      logic [1:0] ea;
      do_reset();
      for (int n = 0; n < 10; n++) load(1, 1'b1, n[1:0], 16'h0100 + 16'(n));
      load(2, 1'b0, 2'd2, 16'h0);
      for (int k = 1; k <= 11; k++) begin
         step();
         eu = ((k >= 2 && k <= 9) || k == 11) ? 4'b0010 : 4'b0000;
         ep = (k == 10) ? 4'b0100 : 4'b0000;
         ea = (k >= 9) ? 2'd2 : 2'd1;
         checks++;
         if (push !== eu || pop !== ep || anchor !== ea) begin
            errors++;
            $display("FAIL seize c%0d got push=%b pop=%b anchor=%0d exp %b/%b/%0d", k, push, pop, anchor, eu, ep, ea);
         end
      end
      checks++;
      if (data[1] !== 16'h0108) begin
         errors++; $display("FAIL seize_held_data got %h exp 0108", data[1]);
      end
   endtask

   task automatic test_stats();
      do_reset();
      st[0] = 2'b01;
      load(1, 1'b0, 2'd1, 16'h0);
      for (int n = 0; n < 6; n++) step();
      checks++;
      if (stall[1] !== EXP_STALL5 || stall[0] !== 16'd0) begin
         errors++; $display("FAIL stats got l1=%0d l0=%0d exp %0d/0", stall[1], stall[0], EXP_STALL5);
      end
      st[0] = 2'b00;
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int n = 0; n < 4; n++) load(1, 1'b1, 2'd3, 16'hBEEF);
      step();
      step();
      checks++;
      if (push !== 4'b0010 || tree[1] !== 2'd3 || data[1] !== 16'hBEEF) begin
         errors++; $display("FAIL midrst_pre got push=%b tree=%0d data=%h exp 0010/3/beef", push, tree[1], data[1]);
      end
      #2;
      arst = 1'b1;
      #1;
      checks++;
      if (push !== 4'b0 || pop !== 4'b0 || tree !== '0 || data !== '0 || anchor !== 2'd1 || stall !== '0) begin
         errors++;
         $display("FAIL midrst_async got push=%b pop=%b tree=%h data=%h anchor=%0d exp all 0, anchor 1", push, pop, tree, data, anchor);
      end
      @(negedge clk);
      arst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      arst = 1'b1;
      st   = '0;
      @(negedge clk);
      test_reset();
      test_push_basic();
      test_push_pop_hazard();
      test_all_pop();
      test_starve_hold();
      test_starve_seize();
      test_stats();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
